// File: rtl/i2c_eeprom_seq.sv
// i2c_eeprom_seq: burst write / read-back sequencer in front of the I2C byte controller.
// Issues BYTE_NUM single-byte transactions at consecutive addresses, stretches i2c_start
// across one controller clock, synchronises i2c_end, and checks read data against the
// seed+index pattern.
module i2c_eeprom_seq #(
    parameter int BYTE_NUM    = 8,          // 1..256
    parameter int I2C_CLK_DIV = 50,         // >= 1
    parameter int WR_GAP_CYC  = 250_000,    // >= 1
    parameter int TIMEOUT_CYC = 2_000_000   // >= 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [15:0] base_addr,
    input  logic [7:0]  seed,
    input  logic        i2c_end,
    input  logic [7:0]  i2c_rd_data,
    output logic        wr_en,
    output logic        rd_en,
    output logic        i2c_start,
    output logic [15:0] byte_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  rd_byte,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  err_cnt
);

    localparam int IDX_W = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BYTE_NUM - 1);
    localparam logic [31:0]      ISSUE_LAST = 32'(I2C_CLK_DIV - 1);
    localparam logic [31:0]      GAP_LAST   = 32'(WR_GAP_CYC - 1);
    localparam logic [31:0]      TO_LAST    = 32'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]       r_state;
    logic [31:0]      r_cnt;       // shared by start hold, watchdog and write gap
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_base;
    logic [7:0]       r_seed;
    logic             r_wr_en;
    logic             r_rd_en;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic [7:0]       r_rd_byte;
    logic             r_rd_valid;
    logic [7:0]       r_err_cnt;
    logic             r_end_s1;
    logic             r_end_s2;
    logic             r_end_s3;

    logic       w_end_rise;
    logic       w_adv;
    logic [7:0] w_exp;

    // Address and pattern come straight from the latched base/seed and the index, so
    // they hold still for the whole transaction without extra registers.
    assign w_exp      = r_seed + 8'(r_idx);
    assign w_end_rise = r_end_s2 & ~r_end_s3;
    // Byte finished: write after its gap, read as soon as its end is seen.
    assign w_adv      = ((r_state == S_GAP) && (r_cnt == GAP_LAST)) ||
                        ((r_state == S_WAIT) && w_end_rise && r_rd_en);

    assign wr_en     = r_wr_en;
    assign rd_en     = r_rd_en;
    assign i2c_start = (r_state == S_ISSUE);
    assign byte_addr = r_base + 16'(r_idx);
    assign wr_data   = w_exp;
    assign rd_byte   = r_rd_byte;
    assign rd_valid  = r_rd_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign err_cnt   = r_err_cnt;

    // Bring the controller's end pulse into sys_clk and keep one stage for edge detect.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_end_s1 <= 1'b0;
            r_end_s2 <= 1'b0;
            r_end_s3 <= 1'b0;
        end else begin
            r_end_s1 <= i2c_end;
            r_end_s2 <= r_end_s1;
            r_end_s3 <= r_end_s2;
        end
    end

    // Burst sequencer: accept, issue, wait for end (with watchdog), gap, advance.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_base     <= '0;
            r_seed     <= '0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_rd_byte  <= '0;
            r_rd_valid <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Write has priority; a simultaneous read request is simply lost.
                    if (wr_req || rd_req) begin
                        r_state   <= S_ISSUE;
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        r_base    <= base_addr;
                        r_seed    <= seed;
                        r_wr_en   <= wr_req;
                        r_rd_en   <= ~wr_req;
                        r_busy    <= 1'b1;
                        r_timeout <= 1'b0;
                        if (!wr_req)
                            r_err_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    // Hold start for a full controller clock so the slow side sees it.
                    if (r_cnt == ISSUE_LAST) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (w_end_rise) begin
                        r_cnt <= '0;
                        if (r_wr_en) begin
                            r_state <= S_GAP;
                        end else begin
                            r_rd_byte  <= i2c_rd_data;
                            r_rd_valid <= 1'b1;
                            if ((i2c_rd_data != w_exp) && (r_err_cnt != 8'hFF))
                                r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        r_state   <= S_IDLE;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_wr_en   <= 1'b0;
                        r_rd_en   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    // S_GAP: EEPROM internal write cycle; exit handled by w_adv below.
                    r_cnt <= r_cnt + 32'd1;
                end
            endcase

            if (w_adv) begin
                r_cnt <= '0;
                if (r_idx == LAST_IDX) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_wr_en <= 1'b0;
                    r_rd_en <= 1'b0;
                end else begin
                    r_state <= S_ISSUE;
                    r_idx   <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_seq.sv
// Bench for i2c_eeprom_seq: EEPROM/controller model, pattern reference model and a
// scoreboard that checks every issued transaction and every read-back strobe.
module tb_i2c_eeprom_seq;

    localparam int BN   = 4;
    localparam int DIV  = 4;
    localparam int GAP  = 20;
    localparam int TOUT = 300;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0;
    logic [15:0] base_addr = '0;
    logic [7:0]  seed = '0;
    logic        i2c_end;
    logic [7:0]  i2c_rd_data;
    logic        wr_en, rd_en, i2c_start, rd_valid, busy, done, timeout;
    logic [15:0] byte_addr;
    logic [7:0]  wr_data, rd_byte, err_cnt;

    i2c_eeprom_seq #(.BYTE_NUM(BN), .I2C_CLK_DIV(DIV), .WR_GAP_CYC(GAP), .TIMEOUT_CYC(TOUT)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_req(wr_req), .rd_req(rd_req),
        .base_addr(base_addr), .seed(seed), .i2c_end(i2c_end), .i2c_rd_data(i2c_rd_data),
        .wr_en(wr_en), .rd_en(rd_en), .i2c_start(i2c_start), .byte_addr(byte_addr),
        .wr_data(wr_data), .rd_byte(rd_byte), .rd_valid(rd_valid), .busy(busy),
        .done(done), .timeout(timeout), .err_cnt(err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          done_seen = 0;
    int          last_end_cyc = 0;
    bit          gap_armed = 0;
    bit          withhold = 0;
    bit          corrupt_en = 0;
    logic [15:0] corrupt_addr = 16'h0012;
    int          ref_err = 0;
    txn_t        exp_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  dev_mem[int];
    logic [7:0]  ref_mem[int];

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Unwritten EEPROM cells read back as a fixed function of the address.
    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Controller + EEPROM model: answers each start with an end pulse one DIV wide.
    initial begin : dev
        logic        dprev;
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        i2c_end = 1'b0;
        i2c_rd_data = 8'h00;
        dprev = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (i2c_start && !dprev) begin
                a = byte_addr; d = wr_data; w = wr_en;
                for (int k = 0; k < 1000 && i2c_start; k++) @(negedge sys_clk);
                if (!withhold && (wr_en || rd_en)) begin
                    if (w) dev_mem[int'(a)] = d;
                    else i2c_rd_data = (corrupt_en && a == corrupt_addr) ? 8'h00 :
                                       (dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : dflt(a));
                    repeat ($urandom_range(1, 8)) @(negedge sys_clk);
                    i2c_end = 1'b1;
                    last_end_cyc = cyc;
                    gap_armed = w;
                    repeat (DIV) @(negedge sys_clk);
                    i2c_end = 1'b0;
                end
                dprev = 1'b0;
            end else begin
                dprev = i2c_start;
            end
        end
    end

    // Scoreboard monitor: transactions on start rise, read data on rd_valid, done count.
    initial begin : mon
        logic        m_prev;
        int          m_width;
        logic [15:0] m_addr;
        txn_t        t;
        logic [7:0]  eb;
        m_prev = 1'b0; m_width = 0; m_addr = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n) begin
                if (i2c_start && !m_prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_txn", {16'h0, byte_addr}, 32'hFFFF_FFFF);
                    end else begin
                        t = exp_q.pop_front();
                        chk("txn_wr_en", wr_en, t.wr);
                        chk("txn_rd_en", rd_en, !t.wr);
                        chk("txn_addr", byte_addr, t.addr);
                        chk("txn_data", wr_data, t.data);
                    end
                    if (gap_armed && wr_en)
                        chk("write_gap", (cyc - last_end_cyc) >= GAP + 3, 1);
                    gap_armed = 0;
                    m_addr = byte_addr;
                    m_width = 0;
                end
                if (i2c_start) begin
                    m_width++;
                end else if (m_prev) begin
                    chk("start_width", m_width, DIV);
                    chk("addr_stable", byte_addr, m_addr);
                end
                if (rd_valid) begin
                    if (exp_rd_q.size() == 0) begin
                        chk("unexpected_rd_valid", rd_byte, 32'hFFFF_FFFF);
                    end else begin
                        eb = exp_rd_q.pop_front();
                        chk("rd_byte", rd_byte, eb);
                    end
                end
                if (done) done_seen++;
            end
            m_prev = i2c_start;
        end
    end

    // Reference model: a burst is BN bytes at base+i (16-bit wrap) with pattern seed+i.
    task automatic issue(input bit w, input bit r, input logic [15:0] b, input logic [7:0] s,
                         input bit commit);
        logic [15:0] a;
        logic [7:0]  p, v;
        for (int i = 0; i < BN; i++) begin
            a = b + 16'(i);
            p = s + 8'(i);
            if (w) begin
                exp_q.push_back('{1'b1, a, p});
                if (commit) ref_mem[int'(a)] = p;
            end else if (r) begin
                if (i == 0) ref_err = 0;
                v = (corrupt_en && a == corrupt_addr) ? 8'h00 :
                    (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a));
                exp_q.push_back('{1'b0, a, p});
                exp_rd_q.push_back(v);
                if (v != p && ref_err < 255) ref_err++;
            end
        end
        gap_armed = 0;
        @(negedge sys_clk);
        wr_req = w; rd_req = r; base_addr = b; seed = s;
        @(negedge sys_clk);
        wr_req = 1'b0; rd_req = 1'b0;
        base_addr = 16'($urandom); seed = 8'($urandom);
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int n);
        ok = 0; n = 0;
        for (int k = 0; k < budget; k++) begin
            if (!busy) begin ok = 1; break; end
            @(negedge sys_clk);
            n++;
        end
    endtask

    task automatic finish_burst(input string tag, input int d0);
        bit ok;
        int n;
        wait_idle(3000, ok, n);
        chk({tag, "_completes"}, ok, 1);
        repeat (3) @(negedge sys_clk);
        chk({tag, "_done_once"}, done_seen - d0, 1);
        chk({tag, "_queue_drained"}, exp_q.size() + exp_rd_q.size(), 0);
        chk({tag, "_idle_outputs"}, {busy, wr_en, rd_en, i2c_start, timeout}, 0);
        chk({tag, "_err_cnt"}, err_cnt, ref_err);
        exp_q.delete(); exp_rd_q.delete();
    endtask

    task automatic burst(input string tag, input bit w, input bit r, input logic [15:0] b,
                         input logic [7:0] s);
        int d0;
        d0 = done_seen;
        issue(w, r, b, s, 1);
        finish_burst(tag, d0);
    endtask

    initial begin : stim
        bit ok;
        int n, d0;
        repeat (3) @(negedge sys_clk);
        chk("reset_outputs", {wr_en, rd_en, i2c_start, byte_addr, wr_data, rd_byte, rd_valid,
                              busy, done, timeout, err_cnt}, 0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("post_reset_idle", {busy, wr_en, rd_en, i2c_start, done}, 0);

        burst("t1_write", 1, 0, 16'h0010, 8'hA0);
        burst("t2_read", 0, 1, 16'h0010, 8'hA0);
        corrupt_en = 1; corrupt_addr = 16'h0012;
        burst("t3_corrupt", 0, 1, 16'h0010, 8'hA0);
        corrupt_en = 0;
        burst("t4_wrap_write", 1, 0, 16'hFFFE, 8'hFF);
        burst("t4_wrap_read", 0, 1, 16'hFFFE, 8'hFF);

        // Withheld end: watchdog must abort without done.
        withhold = 1;
        d0 = done_seen;
        issue(1, 0, 16'h0200, 8'h33, 0);
        wait_idle(TOUT + 200, ok, n);
        chk("t5_abort", ok, 1);
        chk("t5_abort_delay", n >= TOUT, 1);
        chk("t5_timeout_flag", timeout, 1);
        chk("t5_abort_outputs", {busy, wr_en, rd_en}, 0);
        repeat (3) @(negedge sys_clk);
        chk("t5_no_done", done_seen - d0, 0);
        exp_q.delete(); exp_rd_q.delete();
        withhold = 0;
        d0 = done_seen;
        issue(1, 0, 16'h0200, 8'h33, 1);
        chk("t5_timeout_cleared", timeout, 0);
        finish_burst("t5_recover", d0);

        // Simultaneous requests: write only. Then a read request during a busy write.
        burst("t6_both", 1, 1, 16'h0300, 8'h10);
        d0 = done_seen;
        issue(1, 0, 16'h0400, 8'h20, 1);
        repeat (10) @(negedge sys_clk);
        rd_req = 1'b1;
        @(negedge sys_clk);
        rd_req = 1'b0;
        finish_burst("t6_rd_while_busy", d0);

        // Reset while start is being held.
        d0 = done_seen;
        issue(1, 0, 16'h0500, 8'h40, 0);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (i2c_start) begin ok = 1; break; end
            @(negedge sys_clk);
        end
        chk("t6_start_seen", ok, 1);
        #2 sys_rst_n = 1'b0;
        #1 chk("t6_async_reset", {wr_en, rd_en, i2c_start, byte_addr, wr_data, rd_byte, rd_valid,
                                  busy, done, timeout, err_cnt}, 0);
        ref_err = 0;
        repeat (3) @(negedge sys_clk);
        exp_q.delete(); exp_rd_q.delete();
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        chk("t6_idle_after_reset", {busy, wr_en, rd_en, i2c_start}, 0);
        chk("t6_no_done", done_seen - d0, 0);

        // Randomised bursts, including near the top of the address space.
        for (int i = 0; i < 10; i++) begin
            logic [15:0] b;
            bit w;
            w = 1'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFB, 16'hFFFF))
                                            : 16'($urandom_range(0, 16'h003F));
            burst(w ? "rnd_write" : "rnd_read", w, !w, b, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
